// File: rtl/i3c_pkg.sv
// Shared definitions for the I3C target interrupt logic.
// Holds the coalescing FSM state encoding and a helper that sizes the
// per-cycle new-event count for a given number of interrupt sources.
package i3c_pkg;

  typedef enum logic [1:0] {
    IRQ_COAL_IDLE  = 2'd0,
    IRQ_COAL_ACCUM = 2'd1,
    IRQ_COAL_FIRE  = 2'd2
  } irq_coal_state_e;

  // Bits needed to hold a popcount of n sources (0..n inclusive).
  function automatic int unsigned evt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tti_irq_coalescer.sv
// Interrupt coalescing engine.
// Counts new events and fires once the count reaches a threshold or a
// timeout expires after the first accumulated event. A zero threshold
// bypasses coalescing and the raw request is registered straight through.
//
// Ports:
//   clk_i          - clock
//   rst_ni         - synchronous active-low reset
//   new_evt_i      - number of events recorded this cycle
//   raw_i          - OR of enabled status bits
//   coal_thld_i    - events needed to fire (0 = passthrough)
//   coal_timeout_i - cycles from first event to forced fire (0 = none)
//   irq_o          - registered interrupt
//   pending_cnt_o  - registered event counter
//   state_o        - current FSM state (debug visibility)
module tti_irq_coalescer
  import i3c_pkg::*;
#(
  parameter int unsigned CntWidth   = 8,
  parameter int unsigned TimerWidth = 16,
  parameter int unsigned EvtW       = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [EvtW-1:0]       new_evt_i,
  input  logic                  raw_i,
  input  logic [CntWidth-1:0]   coal_thld_i,
  input  logic [TimerWidth-1:0] coal_timeout_i,
  output logic                  irq_o,
  output logic [CntWidth-1:0]   pending_cnt_o,
  output irq_coal_state_e       state_o
);

  // Wide enough that counter + new_evt never wraps before saturation.
  localparam int unsigned SumW = CntWidth + EvtW;
  localparam logic [CntWidth-1:0]   CntMax = '1;
  localparam logic [TimerWidth-1:0] TmrMax = '1;

  irq_coal_state_e       r_state, w_state_d;
  logic [CntWidth-1:0]   r_cnt, w_cnt_d;
  logic [TimerWidth-1:0] r_tmr, w_tmr_d;
  logic                  r_irq, w_irq_d;

  logic [SumW-1:0]       w_sum;
  logic [CntWidth-1:0]   w_cnt_sat;
  logic [TimerWidth-1:0] w_tmr_inc;
  logic                  w_fire_hit;

  // The counter is zero outside ACCUM/FIRE, so the same saturating sum
  // serves both the IDLE load and the ACCUM accumulate.
  assign w_sum      = SumW'(r_cnt) + SumW'(new_evt_i);
  assign w_cnt_sat  = (w_sum > SumW'(CntMax)) ? CntMax : w_sum[CntWidth-1:0];
  assign w_tmr_inc  = (r_tmr == TmrMax) ? r_tmr : r_tmr + TimerWidth'(1);
  assign w_fire_hit = (w_cnt_sat >= coal_thld_i) ||
                      ((coal_timeout_i != '0) && (w_tmr_inc >= coal_timeout_i));

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_tmr_d   = r_tmr;
    w_irq_d   = 1'b0;
    if (coal_thld_i == '0) begin
      // Passthrough: FSM parked, request registered directly.
      w_state_d = IRQ_COAL_IDLE;
      w_cnt_d   = '0;
      w_tmr_d   = '0;
      w_irq_d   = raw_i;
    end else begin
      case (r_state)
        IRQ_COAL_IDLE: begin
          w_cnt_d = '0;
          w_tmr_d = '0;
          if (new_evt_i != '0) begin
            w_cnt_d   = w_cnt_sat;
            w_state_d = IRQ_COAL_ACCUM;
          end
        end
        IRQ_COAL_ACCUM: begin
          w_cnt_d = w_cnt_sat;
          w_tmr_d = w_tmr_inc;
          if (w_fire_hit) begin
            w_state_d = IRQ_COAL_FIRE;
          end else if (!raw_i && (new_evt_i == '0)) begin
            // Software cleared everything before the fire point.
            w_state_d = IRQ_COAL_IDLE;
            w_cnt_d   = '0;
            w_tmr_d   = '0;
          end
        end
        IRQ_COAL_FIRE: begin
          // Events here only update status; the count is frozen.
          w_irq_d = raw_i;
          if (!raw_i) begin
            w_state_d = IRQ_COAL_IDLE;
            w_cnt_d   = '0;
            w_tmr_d   = '0;
          end
        end
        default: begin
          w_state_d = IRQ_COAL_IDLE;
          w_cnt_d   = '0;
          w_tmr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IRQ_COAL_IDLE;
      r_cnt   <= '0;
      r_tmr   <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_tmr   <= w_tmr_d;
      r_irq   <= w_irq_d;
    end
  end

  assign irq_o         = r_irq;
  assign pending_cnt_o = r_cnt;
  assign state_o       = r_state;

endmodule

// File: rtl/tti_irq_agg.sv
// TTI interrupt aggregator.
// An array of sticky status bits (enable, force, hardware and software
// clear per source) feeding a coalescing engine that drives one interrupt.
//
// Ports:
//   clk_i          - clock
//   rst_ni         - synchronous active-low reset
//   set_i          - per-source event pulses
//   clr_i          - per-source hardware clear pulses
//   sw_clr_i       - per-source software W1C clear pulses
//   force_i        - per-source software force pulses
//   sts_ena_i      - gates recording of set_i
//   sig_ena_i      - gates contribution of status to the interrupt
//   coal_thld_i    - coalescing threshold (0 = passthrough)
//   coal_timeout_i - coalescing timeout in cycles (0 = none)
//   sts_o          - registered status bits
//   pending_cnt_o  - registered coalescing count
//   irq_o          - registered interrupt
//   coal_state_o   - coalescing FSM state (debug visibility)
module tti_irq_agg
  import i3c_pkg::*;
#(
  parameter int unsigned         NumIrq     = 4,
  parameter int unsigned         CntWidth   = 8,
  parameter int unsigned         TimerWidth = 16,
  parameter logic [NumIrq-1:0]   DelayMask  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumIrq-1:0]     set_i,
  input  logic [NumIrq-1:0]     clr_i,
  input  logic [NumIrq-1:0]     sw_clr_i,
  input  logic [NumIrq-1:0]     force_i,
  input  logic [NumIrq-1:0]     sts_ena_i,
  input  logic [NumIrq-1:0]     sig_ena_i,
  input  logic [CntWidth-1:0]   coal_thld_i,
  input  logic [TimerWidth-1:0] coal_timeout_i,
  output logic [NumIrq-1:0]     sts_o,
  output logic [CntWidth-1:0]   pending_cnt_o,
  output logic                  irq_o,
  output irq_coal_state_e       coal_state_o
);

  localparam int unsigned EvtW = evt_width(NumIrq);

  logic [NumIrq-1:0] r_set_q;
  logic [NumIrq-1:0] r_sts;
  logic [NumIrq-1:0] w_set_eff;
  logic [NumIrq-1:0] w_new_bits;
  logic [NumIrq-1:0] w_clr;
  logic [NumIrq-1:0] w_sts_d;
  logic              w_raw;
  logic [EvtW-1:0]   w_new_evt;

  // Delayed sources use last cycle's pulse so they line up with the
  // queue flag updates they report on.
  assign w_set_eff  = (DelayMask & r_set_q) | (~DelayMask & set_i);
  assign w_new_bits = (w_set_eff & sts_ena_i) | force_i;
  // A set or force in the same cycle beats a clear so no event is lost.
  assign w_clr      = (clr_i | sw_clr_i) & ~w_new_bits;
  assign w_sts_d    = (r_sts | w_new_bits) & ~w_clr;
  assign w_raw      = |(r_sts & sig_ena_i);

  // Every recorded event counts, including repeats on already-set bits.
  always_comb begin
    w_new_evt = '0;
    for (int i = 0; i < NumIrq; i++) begin
      w_new_evt = w_new_evt + EvtW'(w_new_bits[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_set_q <= '0;
      r_sts   <= '0;
    end else begin
      r_set_q <= set_i;
      r_sts   <= w_sts_d;
    end
  end

  tti_irq_coalescer #(
    .CntWidth   (CntWidth),
    .TimerWidth (TimerWidth),
    .EvtW       (EvtW)
  ) u_coalescer (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .new_evt_i      (w_new_evt),
    .raw_i          (w_raw),
    .coal_thld_i    (coal_thld_i),
    .coal_timeout_i (coal_timeout_i),
    .irq_o          (irq_o),
    .pending_cnt_o  (pending_cnt_o),
    .state_o        (coal_state_o)
  );

  assign sts_o = r_sts;

endmodule
